// File: rtl/int_ctrl.sv
// Interrupt controller feeding the program counter: latches IRQ rising edges,
// masks/prioritises them and issues a one-cycle INTjmp with the vector address.
module int_ctrl #(
    parameter int          NIRQ       = 8,
    parameter logic [15:0] VEC_BASE   = 16'hFF00,
    parameter int          VEC_STRIDE = 4
) (
    input  logic            CLK,
    input  logic            RSTn,
    input  logic [NIRQ-1:0] IRQ,
    input  logic            GIE,
    input  logic            Boundary,
    input  logic            Reti,
    input  logic            MaskWr,
    input  logic [NIRQ-1:0] MaskIn,
    input  logic            ClrWr,
    input  logic [NIRQ-1:0] ClrIn,
    output logic            INTjmp,
    output logic [15:0]     Aint,
    output logic            IntAct,
    output logic [3:0]      IntId,
    output logic [NIRQ-1:0] Pending,
    output logic [NIRQ-1:0] Mask
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_TAKE    = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [NIRQ-1:0] r_irq_q;
    logic [NIRQ-1:0] r_pending;
    logic [NIRQ-1:0] r_mask;
    logic            r_intjmp;
    logic [15:0]     r_aint;
    logic            r_intact;
    logic [3:0]      r_intid;

    logic [NIRQ-1:0] w_edge;
    logic [NIRQ-1:0] w_elig;
    logic [NIRQ-1:0] w_lowest;
    logic [NIRQ-1:0] w_take_oh;
    logic [NIRQ-1:0] w_clr;
    logic [3:0]      w_idx;
    logic            w_take;

    function automatic logic [15:0] f_vec_addr(input logic [3:0] idx);
        return VEC_BASE + 16'(idx) * 16'(VEC_STRIDE);
    endfunction

    assign w_edge    = IRQ & ~r_irq_q;
    assign w_elig    = r_pending & r_mask & {NIRQ{GIE}};
    // Isolates the lowest set bit: fixed priority, lowest index wins.
    assign w_lowest  = w_elig & (~w_elig + NIRQ'(1));
    assign w_take_oh = w_take ? w_lowest : '0;
    assign w_clr     = ClrWr ? ClrIn : '0;

    always_comb begin
        w_idx = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_idx = 4'(i);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if ((|w_elig) && Boundary) begin
                    w_take      = 1'b1;
                    w_state_nxt = S_TAKE;
                end
            end
            S_TAKE:    w_state_nxt = S_SERVICE;
            S_SERVICE: if (Reti) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_irq_q   <= '0;
            r_pending <= '0;
            r_mask    <= '0;
            r_intjmp  <= 1'b0;
            r_aint    <= VEC_BASE;
            r_intact  <= 1'b0;
            r_intid   <= '0;
        end else begin
            r_irq_q   <= IRQ;
            // A fresh edge beats both a software clear and the take clear.
            r_pending <= (r_pending & ~w_clr & ~w_take_oh) | w_edge;
            if (MaskWr) begin
                r_mask <= MaskIn;
            end
            r_intjmp <= w_take;
            if (w_take) begin
                r_aint  <= f_vec_addr(w_idx);
                r_intid <= w_idx;
            end
            if (r_state == S_TAKE) begin
                r_intact <= 1'b1;
            end else if (r_state == S_SERVICE && Reti) begin
                r_intact <= 1'b0;
            end
        end
    end

    assign INTjmp  = r_intjmp;
    assign Aint    = r_aint;
    assign IntAct  = r_intact;
    assign IntId   = r_intid;
    assign Pending = r_pending;
    assign Mask    = r_mask;

endmodule
